// File: rtl/cr16_pkg.sv
// Shared definitions for the CR16 ALU controller: instruction fields, op/ext
// encodings, ALU opcodes, status bit indices and decoded-control types.
package cr16_pkg;

   // Instruction field positions
   localparam int OP_HI  = 15;
   localparam int OP_LO  = 12;
   localparam int RD_HI  = 11;
   localparam int RD_LO  = 8;
   localparam int EXT_HI = 7;
   localparam int EXT_LO = 4;
   localparam int RS_HI  = 3;
   localparam int RS_LO  = 0;
   localparam int IMM_HI = 7;
   localparam int IMM_LO = 0;

   // Operation codes: the ext field in register form, the op field in immediate form
   localparam logic [3:0] CODE_REG   = 4'b0000;
   localparam logic [3:0] CODE_AND   = 4'b0001;
   localparam logic [3:0] CODE_OR    = 4'b0010;
   localparam logic [3:0] CODE_XOR   = 4'b0011;
   localparam logic [3:0] CODE_ADD   = 4'b0101;
   localparam logic [3:0] CODE_ADDU  = 4'b0110;
   localparam logic [3:0] CODE_ADDC  = 4'b0111;
   localparam logic [3:0] CODE_SHIFT = 4'b1000;
   localparam logic [3:0] CODE_SUB   = 4'b1001;
   localparam logic [3:0] CODE_CMP   = 4'b1011;
   localparam logic [3:0] CODE_MOV   = 4'b1101;

   // ALU opcodes
   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_ADDU = 4'd1;
   localparam logic [3:0] ALU_ADDC = 4'd2;
   localparam logic [3:0] ALU_SUB  = 4'd4;
   localparam logic [3:0] ALU_AND  = 4'd6;
   localparam logic [3:0] ALU_OR   = 4'd7;
   localparam logic [3:0] ALU_XOR  = 4'd8;
   localparam logic [3:0] ALU_LSH  = 4'd10;
   localparam logic [3:0] ALU_RSH  = 4'd11;

   // Status / PSR bit indices
   localparam int ST_C = 0;
   localparam int ST_L = 1;
   localparam int ST_F = 2;
   localparam int ST_Z = 3;
   localparam int ST_N = 4;

   typedef enum logic [1:0] {A_RSRC, A_IMM, A_RDEST} a_sel_e;
   typedef enum logic [1:0] {B_RDEST, B_IMM, B_ZERO} b_sel_e;

   typedef struct packed {
      logic [3:0] opcode;
      a_sel_e     a_sel;
      b_sel_e     b_sel;
      logic       wb_en;
      logic       psr_en;
   } ctrl_t;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_e;

endpackage

// File: rtl/cr16_decoder.sv
// Combinational CR16 instruction decoder. Shift decode (op 1000) exists only
// when CR16_SHIFT_EN is defined; otherwise that encoding is illegal.
module cr16_decoder
   import cr16_pkg::*;
#(
   parameter int P_WIDTH = 16
) (
   input  logic [15:0]        i_instr,
   input  logic               i_carry,
   output ctrl_t              o_ctrl,
   output logic [P_WIDTH-1:0] o_imm,
   output logic               o_illegal
);

   logic [3:0] w_op;
   logic [3:0] w_ext;
   logic [3:0] w_code;
   logic       w_reg_form;
   logic       w_sext;

   assign w_op       = i_instr[OP_HI:OP_LO];
   assign w_ext      = i_instr[EXT_HI:EXT_LO];
   assign w_reg_form = (w_op == CODE_REG);
   assign w_code     = w_reg_form ? w_ext : w_op;

   always_comb begin
      // NOTE: every output gets a default before any branch so no latch is inferred.
      o_ctrl.opcode = ALU_ADD;
      o_ctrl.a_sel  = w_reg_form ? A_RSRC : A_IMM;
      o_ctrl.b_sel  = B_RDEST;
      o_ctrl.wb_en  = 1'b1;
      o_ctrl.psr_en = 1'b1;
      o_imm         = {{(P_WIDTH-8){1'b0}}, i_instr[IMM_HI:IMM_LO]};
      o_illegal     = 1'b0;
      w_sext        = 1'b0;

      if (!w_reg_form && (w_op == CODE_SHIFT)) begin
`ifdef CR16_SHIFT_EN
         if (i_instr[7:5] == 3'b000) begin
            o_ctrl.opcode = i_instr[4] ? ALU_RSH : ALU_LSH;
            o_ctrl.a_sel  = A_RDEST;
            o_ctrl.b_sel  = B_IMM;
            o_imm         = {{(P_WIDTH-4){1'b0}}, i_instr[3:0]};
         end else begin
            o_illegal = 1'b1;
         end
`else
         o_illegal = 1'b1;
`endif
      end else begin
         case (w_code)
            CODE_AND:  o_ctrl.opcode = ALU_AND;
            CODE_OR:   o_ctrl.opcode = ALU_OR;
            CODE_XOR:  o_ctrl.opcode = ALU_XOR;
            CODE_ADDU: o_ctrl.opcode = ALU_ADDU;
            CODE_ADD: begin
               o_ctrl.opcode = ALU_ADD;
               w_sext        = 1'b1;
            end
            CODE_ADDC: begin
               o_ctrl.opcode = i_carry ? ALU_ADDC : ALU_ADD;
               w_sext        = 1'b1;
            end
            CODE_SUB: begin
               o_ctrl.opcode = ALU_SUB;
               w_sext        = 1'b1;
            end
            CODE_CMP: begin
               o_ctrl.opcode = ALU_SUB;
               o_ctrl.wb_en  = 1'b0;
               w_sext        = 1'b1;
            end
            CODE_MOV: begin
               // OR against a zero B operand passes A straight through
               o_ctrl.opcode = ALU_OR;
               o_ctrl.b_sel  = B_ZERO;
               o_ctrl.psr_en = 1'b0;
            end
            default: o_illegal = 1'b1;
         endcase
         if (w_sext && !w_reg_form)
            o_imm = {{(P_WIDTH-8){i_instr[7]}}, i_instr[IMM_HI:IMM_LO]};
      end

      if (o_illegal) begin
         o_ctrl.wb_en  = 1'b0;
         o_ctrl.psr_en = 1'b0;
      end
   end

endmodule

// File: rtl/cr16_alu_ctrl.sv
// CR16 ALU controller: IDLE -> EXEC -> WB sequencer around cr16_decoder.
// Optional shift instructions are enabled with the CR16_SHIFT_EN macro.
module cr16_alu_ctrl
   import cr16_pkg::*;
#(
   parameter int P_WIDTH = 16
) (
   input  logic               I_CLK,
   input  logic               I_NRESET,
   input  logic               I_INSTR_VALID,
   output logic               O_INSTR_READY,
   input  logic [15:0]        I_INSTR,
   output logic [3:0]         O_RDEST_ADDR,
   output logic [3:0]         O_RSRC_ADDR,
   input  logic [P_WIDTH-1:0] I_RDEST_DATA,
   input  logic [P_WIDTH-1:0] I_RSRC_DATA,
   output logic               O_ALU_ENABLE,
   output logic [3:0]         O_ALU_OPCODE,
   output logic [P_WIDTH-1:0] O_ALU_A,
   output logic [P_WIDTH-1:0] O_ALU_B,
   input  logic [P_WIDTH-1:0] I_ALU_C,
   input  logic [4:0]         I_ALU_STATUS,
   output logic               O_WB_EN,
   output logic [3:0]         O_WB_ADDR,
   output logic [P_WIDTH-1:0] O_WB_DATA,
   output logic [4:0]         O_PSR,
   output logic               O_ILLEGAL
);

   state_e             r_state;
   state_e             w_next;
   logic               r_ready;
   logic               r_illegal;
   logic [3:0]         r_rdest;
   logic [3:0]         r_rsrc;
   ctrl_t              r_ctrl;
   logic [P_WIDTH-1:0] r_imm;
   logic [4:0]         r_psr;

   ctrl_t              w_dec_ctrl;
   logic [P_WIDTH-1:0] w_dec_imm;
   logic               w_dec_illegal;
   logic               w_accept;

   // Carry is stable between accept and EXEC, so decoding at accept time is safe
   cr16_decoder #(.P_WIDTH(P_WIDTH)) u_decoder (
      .i_instr   (I_INSTR),
      .i_carry   (r_psr[ST_C]),
      .o_ctrl    (w_dec_ctrl),
      .o_imm     (w_dec_imm),
      .o_illegal (w_dec_illegal)
   );

   assign w_accept = I_INSTR_VALID & r_ready;

   always_ff @(posedge I_CLK or negedge I_NRESET) begin
      if (!I_NRESET) begin
         r_state <= S_IDLE;
         r_ready <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         r_state <= w_next;
         r_ready <= (w_next == S_IDLE);
      end
   end

   always_ff @(posedge I_CLK or negedge I_NRESET) begin
      if (!I_NRESET) begin
         r_illegal <= 1'b0;
         r_rdest   <= '0;
         r_rsrc    <= '0;
         r_ctrl    <= '0;
         r_imm     <= '0;
         r_psr     <= '0;
      end else begin
         r_illegal <= w_accept & w_dec_illegal;
         if (w_accept) begin
            r_rdest <= I_INSTR[RD_HI:RD_LO];
            r_rsrc  <= I_INSTR[RS_HI:RS_LO];
            r_ctrl  <= w_dec_ctrl;
            r_imm   <= w_dec_imm;
         end
         if ((r_state == S_WB) && r_ctrl.psr_en)
            r_psr <= I_ALU_STATUS;
      end
   end

   always_comb begin
      w_next       = r_state;
      O_ALU_ENABLE = 1'b0;
      O_ALU_OPCODE = '0;
      O_ALU_A      = '0;
      O_ALU_B      = '0;
      O_WB_EN      = 1'b0;
      O_WB_ADDR    = '0;
      O_WB_DATA    = '0;

      case (r_state)
         S_IDLE: begin
            if (w_accept && !w_dec_illegal)
               w_next = S_EXEC;
         end
         S_EXEC: begin
            w_next       = S_WB;
            O_ALU_ENABLE = 1'b1;
            O_ALU_OPCODE = r_ctrl.opcode;
            case (r_ctrl.a_sel)
               A_RSRC:  O_ALU_A = I_RSRC_DATA;
               A_IMM:   O_ALU_A = r_imm;
               A_RDEST: O_ALU_A = I_RDEST_DATA;
               default: O_ALU_A = '0;
            endcase
            case (r_ctrl.b_sel)
               B_RDEST: O_ALU_B = I_RDEST_DATA;
               B_IMM:   O_ALU_B = r_imm;
               default: O_ALU_B = '0;
            endcase
         end
         S_WB: begin
            w_next    = S_IDLE;
            O_WB_EN   = r_ctrl.wb_en;
            O_WB_ADDR = r_rdest;
            O_WB_DATA = I_ALU_C;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign O_INSTR_READY = r_ready;
   assign O_ILLEGAL     = r_illegal;
   assign O_PSR         = r_psr;
   assign O_RDEST_ADDR  = r_rdest;
   assign O_RSRC_ADDR   = r_rsrc;

endmodule

// File: tb/tb_cr16_alu_ctrl.sv
// Directed bench for cr16_alu_ctrl with a register-file model and a registered
// ALU model; expected values are worked out by hand for each vector.
module tb_cr16_alu_ctrl;

   logic        I_CLK = 1'b0;
   logic        I_NRESET = 1'b0;
   logic        I_INSTR_VALID = 1'b0;
   logic [15:0] I_INSTR = 16'h0000;
   logic        O_INSTR_READY;
   logic [3:0]  O_RDEST_ADDR, O_RSRC_ADDR;
   logic [15:0] I_RDEST_DATA, I_RSRC_DATA;
   logic        O_ALU_ENABLE;
   logic [3:0]  O_ALU_OPCODE;
   logic [15:0] O_ALU_A, O_ALU_B;
   logic [15:0] I_ALU_C = 16'h0000;
   logic [4:0]  I_ALU_STATUS = 5'b00000;
   logic        O_WB_EN;
   logic [3:0]  O_WB_ADDR;
   logic [15:0] O_WB_DATA;
   logic [4:0]  O_PSR;
   logic        O_ILLEGAL;

   logic [15:0] regs [16];
   int n_cmp = 0;
   int n_err = 0;

   cr16_alu_ctrl #(.P_WIDTH(16)) dut (
      .I_CLK(I_CLK), .I_NRESET(I_NRESET),
      .I_INSTR_VALID(I_INSTR_VALID), .O_INSTR_READY(O_INSTR_READY), .I_INSTR(I_INSTR),
      .O_RDEST_ADDR(O_RDEST_ADDR), .O_RSRC_ADDR(O_RSRC_ADDR),
      .I_RDEST_DATA(I_RDEST_DATA), .I_RSRC_DATA(I_RSRC_DATA),
      .O_ALU_ENABLE(O_ALU_ENABLE), .O_ALU_OPCODE(O_ALU_OPCODE),
      .O_ALU_A(O_ALU_A), .O_ALU_B(O_ALU_B),
      .I_ALU_C(I_ALU_C), .I_ALU_STATUS(I_ALU_STATUS),
      .O_WB_EN(O_WB_EN), .O_WB_ADDR(O_WB_ADDR), .O_WB_DATA(O_WB_DATA),
      .O_PSR(O_PSR), .O_ILLEGAL(O_ILLEGAL)
   );

   always #5 I_CLK = ~I_CLK;

   assign I_RDEST_DATA = regs[O_RDEST_ADDR];
   assign I_RSRC_DATA  = regs[O_RSRC_ADDR];

   // ALU model: returns {status[4:0], result[15:0]}, status = {N,Z,F,L,C}
   function automatic logic [20:0] alu_f(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      logic [16:0] s;
      logic [15:0] c;
      logic [4:0]  st;
      s  = '0;
      c  = '0;
      st = '0;
      case (op)
         4'd0, 4'd1, 4'd2: begin
            s     = {1'b0, a} + {1'b0, b} + {16'd0, (op == 4'd2)};
            c     = s[15:0];
            st[0] = s[16];
            st[2] = (a[15] == b[15]) && (c[15] != a[15]);
         end
         4'd4: begin
            c     = b - a;
            st[0] = (a > b);
            st[1] = (a > b);
            st[2] = (a[15] != b[15]) && (c[15] != b[15]);
         end
         4'd6:  c = a & b;
         4'd7:  c = a | b;
         4'd8:  c = a ^ b;
         4'd10: c = a << b[3:0];
         4'd11: c = a >> b[3:0];
         default: c = '0;
      endcase
      if (op == 4'd4) begin
         st[3] = (a == b);
         st[4] = ($signed(a) > $signed(b));
      end else begin
         st[3] = (c == 16'h0000);
         st[4] = c[15];
      end
      return {st, c};
   endfunction

   always @(posedge I_CLK)
      if (O_ALU_ENABLE) {I_ALU_STATUS, I_ALU_C} <= alu_f(O_ALU_OPCODE, O_ALU_A, O_ALU_B);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Issue one legal instruction and check the EXEC and WB cycles. Valid stays
   // high with an illegal word during EXEC/WB to show it is ignored there.
   task automatic run_instr(input string name, input logic [15:0] instr, input logic [3:0] op,
                            input logic [15:0] a, input logic [15:0] b, input logic wb,
                            input logic [3:0] wa, input logic [15:0] wd);
      @(negedge I_CLK);
      check({name, "/ready"}, O_INSTR_READY, 1);
      I_INSTR_VALID = 1'b1;
      I_INSTR       = instr;
      @(negedge I_CLK);
      I_INSTR = 16'hE000;
      check({name, "/exec_en"}, O_ALU_ENABLE, 1);
      check({name, "/opcode"}, O_ALU_OPCODE, op);
      check({name, "/alu_a"}, O_ALU_A, a);
      check({name, "/alu_b"}, O_ALU_B, b);
      check({name, "/exec_ready"}, O_INSTR_READY, 0);
      check({name, "/exec_wb"}, O_WB_EN, 0);
      @(negedge I_CLK);
      check({name, "/wb_alu_en"}, O_ALU_ENABLE, 0);
      check({name, "/wb_en"}, O_WB_EN, wb);
      if (wb) begin
         check({name, "/wb_addr"}, O_WB_ADDR, wa);
         check({name, "/wb_data"}, O_WB_DATA, wd);
      end
      check({name, "/wb_illegal"}, O_ILLEGAL, 0);
      I_INSTR_VALID = 1'b0;
      @(negedge I_CLK);
      check({name, "/done_ready"}, O_INSTR_READY, 1);
      check({name, "/done_wb"}, O_WB_EN, 0);
      check({name, "/done_illegal"}, O_ILLEGAL, 0);
   endtask

   task automatic run_illegal(input string name, input logic [15:0] instr, input logic [4:0] psr);
      @(negedge I_CLK);
      check({name, "/ready"}, O_INSTR_READY, 1);
      I_INSTR_VALID = 1'b1;
      I_INSTR       = instr;
      @(negedge I_CLK);
      I_INSTR_VALID = 1'b0;
      check({name, "/pulse"}, O_ILLEGAL, 1);
      check({name, "/alu_en"}, O_ALU_ENABLE, 0);
      check({name, "/wb_en"}, O_WB_EN, 0);
      check({name, "/ready_back"}, O_INSTR_READY, 1);
      @(negedge I_CLK);
      check({name, "/pulse_end"}, O_ILLEGAL, 0);
      check({name, "/alu_en2"}, O_ALU_ENABLE, 0);
      check({name, "/wb_en2"}, O_WB_EN, 0);
      check({name, "/psr"}, O_PSR, psr);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) regs[i] = 16'h0000;

      // Reset state
      repeat (2) @(negedge I_CLK);
      check("rst/ready", O_INSTR_READY, 0);
      check("rst/alu_en", O_ALU_ENABLE, 0);
      check("rst/wb_en", O_WB_EN, 0);
      check("rst/illegal", O_ILLEGAL, 0);
      check("rst/psr", O_PSR, 0);
      check("rst/opcode", O_ALU_OPCODE, 0);
      check("rst/alu_a", O_ALU_A, 0);
      check("rst/alu_b", O_ALU_B, 0);
      check("rst/wb_addr", O_WB_ADDR, 0);
      check("rst/wb_data", O_WB_DATA, 0);
      I_NRESET = 1'b1;
      #1 check("rel/ready_before_edge", O_INSTR_READY, 0);

      // ADD R1=5, R2=7: A=Rsrc=7, B=Rdest=5, 12
      regs[1] = 16'd5; regs[2] = 16'd7;
      run_instr("add", 16'h0152, 4'd0, 16'd7, 16'd5, 1'b1, 4'd1, 16'd12);
      check("add/psr", O_PSR, 5'b00000);

      // CMP R3=3, R4=5: SUB opcode, no write-back, N=1 Z=0
      regs[3] = 16'd3; regs[4] = 16'd5;
      run_instr("cmp", 16'h03B4, 4'd4, 16'd5, 16'd3, 1'b0, 4'd0, 16'd0);
      check("cmp/psr_n", O_PSR[4], 1);
      check("cmp/psr_z", O_PSR[3], 0);

      // ADDUI R1=FFFF + 1 -> 0, C=1 Z=1 (PSR 01001)
      regs[1] = 16'hFFFF;
      run_instr("addui", 16'h6101, 4'd1, 16'h0001, 16'hFFFF, 1'b1, 4'd1, 16'h0000);
      check("addui/psr_c", O_PSR[0], 1);
      check("addui/psr_z", O_PSR[3], 1);

      // Illegal op 1110 leaves PSR at 01001
      run_illegal("ill_op", 16'hE000, 5'b01001);

      // ADDCI with carry set: opcode 2, 0+0+1
      regs[2] = 16'h0000;
      run_instr("addci", 16'h7200, 4'd2, 16'h0000, 16'h0000, 1'b1, 4'd2, 16'h0001);
      check("addci/psr", O_PSR, 5'b00000);

      // ADDI sign-extends 0x80; 0x0010 + 0xFF80 = 0xFF90, N=1
      regs[1] = 16'h0010;
      run_instr("addi", 16'h5180, 4'd0, 16'hFF80, 16'h0010, 1'b1, 4'd1, 16'hFF90);
      check("addi/psr", O_PSR, 5'b10000);

      // MOVI: OR with B forced to 0, PSR untouched
      run_instr("movi", 16'hD100, 4'd7, 16'h0000, 16'h0000, 1'b1, 4'd1, 16'h0000);
      check("movi/psr", O_PSR, 5'b10000);

      // MOV R1 <- R2
      regs[2] = 16'h1234;
      run_instr("mov", 16'h01D2, 4'd7, 16'h1234, 16'h0000, 1'b1, 4'd1, 16'h1234);
      check("mov/psr", O_PSR, 5'b10000);

      // ORI zero-extends 0x80
      regs[1] = 16'h0001;
      run_instr("ori", 16'h2180, 4'd7, 16'h0080, 16'h0001, 1'b1, 4'd1, 16'h0081);
      check("ori/psr", O_PSR, 5'b00000);

      // XOR R6=00FF, R7=0F0F
      regs[6] = 16'h00FF; regs[7] = 16'h0F0F;
      run_instr("xor", 16'h0637, 4'd8, 16'h0F0F, 16'h00FF, 1'b1, 4'd6, 16'h0FF0);

      // Register form with ext 1000 is never legal; CMP again to get a nonzero PSR first
      regs[3] = 16'd3; regs[4] = 16'd5;
      run_instr("cmp2", 16'h03B4, 4'd4, 16'd5, 16'd3, 1'b0, 4'd0, 16'd0);
      run_illegal("ill_ext", 16'h0180, 5'b10011);

      // Reset during EXEC aborts the instruction
      regs[1] = 16'd5; regs[2] = 16'd7;
      @(negedge I_CLK);
      I_INSTR_VALID = 1'b1;
      I_INSTR       = 16'h0152;
      @(negedge I_CLK);
      I_INSTR_VALID = 1'b0;
      check("abort/exec_en", O_ALU_ENABLE, 1);
      I_NRESET = 1'b0;
      #1;
      check("abort/alu_en", O_ALU_ENABLE, 0);
      check("abort/ready", O_INSTR_READY, 0);
      @(negedge I_CLK);
      check("abort/wb_en", O_WB_EN, 0);
      check("abort/psr", O_PSR, 5'b00000);
      I_NRESET = 1'b1;
      run_instr("add_after_rst", 16'h0152, 4'd0, 16'd7, 16'd5, 1'b1, 4'd1, 16'd12);
      check("add_after_rst/psr", O_PSR, 5'b00000);

      // Shift R5=1 left by 3
      regs[5] = 16'd1;
`ifdef CR16_SHIFT_EN
      run_instr("lsh", 16'h8503, 4'd10, 16'd1, 16'd3, 1'b1, 4'd5, 16'd8);
`else
      run_illegal("lsh_off", 16'h8503, 5'b00000);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
